stream_gather: RTL



---
 rtl/stream_gather.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/stream_gather.sv
// stream_gather: buffers n valid/ready streams, emits one aligned wide beat.
// Define STREAM_GATHER_CHECK_EN to enable the sticky oerr misalignment flag.
module stream_gather #(
    parameter int n     = 4,
    parameter int p     = 1,
    parameter int DEPTH = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [n-1:0]      inputSelect,
    input  logic [16*p*n-1:0] idata,
    input  logic [n-1:0]      ivalid,
    output logic [n-1:0]      iready,
    input  logic [n-1:0]      istart,
    input  logic [n-1:0]      ilast,
    output logic [16*p*n-1:0] odata,
    output logic              ovalid,
    input  logic              oready,
    output logic              ostart,
    output logic              olast,
    output logic              oerr
);
    localparam int W  = 16 * p;
    localparam int DW = W * n;
    localparam int AW = $clog2(DEPTH);
    localparam int EW = W + 2;
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [EW-1:0] r_mem [n][DEPTH];
    logic [AW:0]   r_wp [n];
    logic [AW:0]   r_rp [n];
    logic [n-1:0]  r_sel;
    state_t        r_state;
    logic          r_ovalid;
    logic          r_ostart;
    logic          r_olast;
    logic [DW-1:0] r_odata;

    logic [n-1:0]  w_empty;
    logic [n-1:0]  w_full;
    logic [n-1:0]  w_push;
    logic [n-1:0]  w_pop;
    logic [n-1:0]  w_iready;
    logic [EW-1:0] w_head [n];
    logic          w_fire;
    logic          w_can_load;
    logic          w_found;
    logic          w_ref_start;
    logic          w_ref_last;
    logic [DW-1:0] w_gdata;

    always_comb begin
        for (int j = 0; j < n; j++) begin
            w_empty[j]  = (r_wp[j] == r_rp[j]);
            w_full[j]   = (r_wp[j][AW] != r_rp[j][AW]) &&
                          (r_wp[j][AW-1:0] == r_rp[j][AW-1:0]);
            w_head[j]   = r_mem[j][r_rp[j][AW-1:0]];
            // unselected inputs always accept and drop
            w_iready[j] = aresetn & (~r_sel[j] | ~w_full[j]);
            w_push[j]   = r_sel[j] & ivalid[j] & w_iready[j];
        end
    end

    assign w_fire = (r_sel != '0) && (&(~r_sel | ~w_empty)) &&
                    (!r_ovalid || oready);
    assign w_pop  = w_fire ? r_sel : '0;
    assign w_can_load = (r_state == IDLE) && (&w_empty) && !r_ovalid;

    always_comb begin
        w_found     = 1'b0;
        w_ref_start = 1'b0;
        w_ref_last  = 1'b0;
        w_gdata     = '0;
        for (int j = 0; j < n; j++) begin
            if (r_sel[j]) begin
                w_gdata[DW-1-W*j -: W] = w_head[j][W-1:0];
                if (!w_found) begin
                    w_found     = 1'b1;
                    w_ref_start = w_head[j][EW-1];
                    w_ref_last  = w_head[j][EW-2];
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        for (int j = 0; j < n; j++) begin
            if (w_push[j]) begin
                r_mem[j][r_wp[j][AW-1:0]] <=
                    {istart[j], ilast[j], idata[DW-1-W*j -: W]};
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int j = 0; j < n; j++) begin
                r_wp[j] <= '0;
                r_rp[j] <= '0;
            end
        end else begin
            for (int j = 0; j < n; j++) begin
                if (w_push[j]) r_wp[j] <= r_wp[j] + PTR_ONE;
                if (w_pop[j])  r_rp[j] <= r_rp[j] + PTR_ONE;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sel    <= '0;
            r_state  <= IDLE;
            r_ovalid <= 1'b0;
            r_odata  <= '0;
            r_ostart <= 1'b0;
            r_olast  <= 1'b0;
        end else begin
            if (w_can_load) r_sel <= inputSelect;
            if (w_fire) begin
                r_ovalid <= 1'b1;
                r_odata  <= w_gdata;
                r_ostart <= w_ref_start;
                r_olast  <= w_ref_last;
            end else if (oready) begin
                r_ovalid <= 1'b0;
            end
            if (r_ovalid && oready) begin
                unique case (r_state)
                    IDLE:   if (r_ostart && !r_olast) r_state <= ACTIVE;
                    ACTIVE: if (r_olast) r_state <= IDLE;
                endcase
            end
        end
    end

`ifdef STREAM_GATHER_CHECK_EN
    logic r_oerr;
    logic w_mis;

    always_comb begin
        w_mis = 1'b0;
        for (int j = 0; j < n; j++) begin
            if (r_sel[j] && ((w_head[j][EW-1] != w_ref_start) ||
                             (w_head[j][EW-2] != w_ref_last))) begin
                w_mis = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_oerr <= 1'b0;
        end else if (w_fire && w_mis) begin
            r_oerr <= 1'b1;
        end
    end

    assign oerr = r_oerr;
`else
    assign oerr = 1'b0;
`endif

    assign iready = w_iready;
    assign odata  = r_odata;
    assign ovalid = r_ovalid;
    assign ostart = r_ostart;
    assign olast  = r_olast;

endmodule
